// File: rtl/tone_pkg.sv
// Shared state/duty encodings and the base period table for tone_gen.
// Duty encodings are only consumed when TONE_DUTY_EN is defined.
package tone_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StStopping
  } tone_state_e;

  typedef enum logic [1:0] {
    Duty12 = 2'd0,
    Duty25 = 2'd1,
    Duty50 = 2'd2,
    Duty75 = 2'd3
  } tone_duty_e;

  localparam int unsigned MinPeriod = 2;

  // Periods in clock cycles for octave 0; higher octaves shift these right.
  function automatic int unsigned base_period(input int unsigned idx);
    int unsigned per;
    case (idx)
      0:       per = 45801;
      1:       per = 40805;
      2:       per = 36352;
      3:       per = 34312;
      4:       per = 30569;
      5:       per = 27234;
      6:       per = 24263;
      default: per = 22901;
    endcase
    return per;
  endfunction

endpackage

// File: rtl/tone_period_lut.sv
// Combinational note/octave (and duty when TONE_DUTY_EN is defined) to period and
// high-phase threshold, with the period clamped to at least MinPeriod.
module tone_period_lut
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NOTE_W = 3,
  parameter int unsigned OCT_W  = 2
) (
  input  logic [NOTE_W-1:0] note_i,
  input  logic [OCT_W-1:0]  octave_i,
`ifdef TONE_DUTY_EN
  input  logic [1:0]        duty_i,
`endif
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  thresh_o
);

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] per;

  always_comb begin
    base    = CNT_W'(base_period(32'(note_i)));
    shifted = base >> octave_i;
    per     = (shifted < CNT_W'(MinPeriod)) ? CNT_W'(MinPeriod) : shifted;
`ifdef TONE_DUTY_EN
    case (tone_duty_e'(duty_i))
      Duty12:  thresh_o = per >> 3;
      Duty25:  thresh_o = per >> 2;
      Duty50:  thresh_o = per >> 1;
      default: thresh_o = per - (per >> 2);
    endcase
`else
    thresh_o = per >> 1;
`endif
    period_o = per;
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator with a one-deep note slot applied only at period boundaries.
// Define TONE_DUTY_EN to add the DUTY input selecting 12.5/25/50/75% high time.
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NOTE_W = 3,
  parameter int unsigned OCT_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              NOTE_VLD,
  output logic              NOTE_RDY,
  input  logic [NOTE_W-1:0] NOTE,
  input  logic [OCT_W-1:0]  OCTAVE,
`ifdef TONE_DUTY_EN
  input  logic [1:0]        DUTY,
`endif
  output logic              SPKR,
  output logic              BUSY
);

  tone_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_per_q, pend_per_d;
  logic [CNT_W-1:0] pend_thr_q, pend_thr_d;
  logic             act_vld_q, act_vld_d;
  logic [CNT_W-1:0] act_per_q, act_per_d;
  logic [CNT_W-1:0] act_thr_q, act_thr_d;
  logic             spkr_q, spkr_d;

  logic [CNT_W-1:0] lut_per;
  logic [CNT_W-1:0] lut_thr;
  logic             accept;
  logic             wrap;
  logic             load_act;

  tone_period_lut #(
    .CNT_W  (CNT_W),
    .NOTE_W (NOTE_W),
    .OCT_W  (OCT_W)
  ) u_lut (
    .note_i   (NOTE),
    .octave_i (OCTAVE),
`ifdef TONE_DUTY_EN
    .duty_i   (DUTY),
`endif
    .period_o (lut_per),
    .thresh_o (lut_thr)
  );

  assign NOTE_RDY = ~pend_vld_q;
  assign accept   = NOTE_VLD & NOTE_RDY;
  assign wrap     = act_vld_q && (cnt_q == act_per_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_per_d = pend_per_q;
    pend_thr_d = pend_thr_q;
    act_vld_d  = act_vld_q;
    act_per_d  = act_per_q;
    act_thr_d  = act_thr_q;
    load_act   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (EN && (pend_vld_q || act_vld_q)) begin
          state_d  = StPlay;
          load_act = pend_vld_q;
        end
      end
      StPlay, StStopping: begin
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
        load_act = wrap && pend_vld_q;
        if (EN) begin
          state_d = StPlay;
        end else if (state_q == StStopping && wrap) begin
          state_d = StIdle;
        end else begin
          state_d = StStopping;
        end
      end
      default: state_d = StIdle;
    endcase

    // A note accepted this cycle sees pend_vld_q=0, so it can never drain in the same cycle.
    if (load_act) begin
      act_vld_d  = 1'b1;
      act_per_d  = pend_per_q;
      act_thr_d  = pend_thr_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_per_d = lut_per;
      pend_thr_d = lut_thr;
    end

    // Register the level for the next cycle's count so SPKR lines up with cnt_q.
    spkr_d = (state_d != StIdle) && (cnt_d < act_thr_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_per_q <= '0;
      pend_thr_q <= '0;
      act_vld_q  <= 1'b0;
      act_per_q  <= '0;
      act_thr_q  <= '0;
      spkr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_per_q <= pend_per_d;
      pend_thr_q <= pend_thr_d;
      act_vld_q  <= act_vld_d;
      act_per_q  <= act_per_d;
      act_thr_q  <= act_thr_d;
      spkr_q     <= spkr_d;
    end
  end

  assign SPKR = spkr_q;
  assign BUSY = (state_q != StIdle);

endmodule
